// File: rtl/jtframe_dwnld_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jtframe_dwnld_pkg
//  Description : Shared types for the ROM download packer: packer/writer state
//                encodings, the FIFO entry layout, the byte-lane mask values
//                and the optional lane-swap helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package jtframe_dwnld_pkg;

    // A 25-bit byte address gives at most a 24-bit word offset. Entries carry
    // this full width. The output stage truncates it to SDRAMW bits.
    localparam int OFFW = 24;

    typedef enum logic [0:0] {
        PK_EMPTY = 1'b0,
        PK_HALF  = 1'b1
    } pack_state_t;

    typedef enum logic [0:0] {
        WR_IDLE  = 1'b0,
        WR_WRITE = 1'b1
    } wr_state_t;

    typedef struct packed {
        logic [1:0]      ba;
        logic [OFFW-1:0] addr;
        logic [15:0]     data;
        logic [1:0]      mask;
    } entry_t;

    // Byte-lane enables, active low; bit 0 is data[7:0]
    localparam logic [1:0] MASK_FULL = 2'b00;
    localparam logic [1:0] MASK_LO   = 2'b10;
    localparam logic [1:0] MASK_HI   = 2'b01;
    localparam logic [1:0] MASK_NONE = 2'b11;

    // Big-endian view of a word: exchange the data lanes and their enables
    function automatic entry_t lane_swap(input entry_t e);
        entry_t r;
        r      = e;
        r.data = {e.data[7:0], e.data[15:8]};
        r.mask = {e.mask[0], e.mask[1]};
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jtframe_dwnld_if.sv
`default_nettype none
// ============================================================================
//  Module      : jtframe_dwnld_if
//  Description : Download-side bundle: ioctl byte stream in, prog_* word
//                writes out, plus busy/overflow status.
//                master : byte source / SDRAM controller side
//                slave  : the packer
//  Revision    : 1.0 - initial release
// ============================================================================
interface jtframe_dwnld_if #(
    parameter int SDRAMW = 23
);
    logic              downloading;
    logic [24:0]       ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic              ioctl_wr;
    logic [SDRAMW-1:0] prog_addr;
    logic [15:0]       prog_data;
    logic [1:0]        prog_mask;
    logic [1:0]        prog_ba;
    logic              prog_we;
    logic              prog_rdy;
    logic              dwnld_busy;
    logic              ovf;

    modport master (
        output downloading, ioctl_addr, ioctl_dout, ioctl_wr, prog_rdy,
        input  prog_addr, prog_data, prog_mask, prog_ba, prog_we,
               dwnld_busy, ovf
    );

    modport slave (
        input  downloading, ioctl_addr, ioctl_dout, ioctl_wr, prog_rdy,
        output prog_addr, prog_data, prog_mask, prog_ba, prog_we,
               dwnld_busy, ovf
    );
endinterface
`default_nettype wire

// File: rtl/jtframe_dwnld_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : jtframe_dwnld_fifo
//  Description : Synchronous word FIFO of entry_t, show-ahead read.
//                DEPTH must be a power of 2 (>= 2).
//  Ports       : clk, rst     - clock, synchronous active-high reset
//                push_i/din_i - write request / entry
//                pop_i        - consume head entry
//                dout_o       - head entry
//                full_o       - no free slot
//                empty_o      - no stored entry
//  Revision    : 1.0 - initial release
// ============================================================================
module jtframe_dwnld_fifo
    import jtframe_dwnld_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push_i,
    input  entry_t din_i,
    input  logic   pop_i,
    output entry_t dout_o,
    output logic   full_o,
    output logic   empty_o
);
    localparam int             PW       = $clog2(DEPTH);
    localparam logic [PW:0]    FULL_CNT = DEPTH[PW:0];

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;
    logic          do_wr;
    logic          do_rd;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign do_rd   = pop_i & ~empty_o;
    // A pop in the same cycle frees the slot the push needs
    assign do_wr   = push_i & (~full_o | do_rd);
    assign dout_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= din_i;
    end
endmodule
`default_nettype wire

// File: rtl/jtframe_dwnld_pack.sv
`default_nettype none
// ============================================================================
//  Module      : jtframe_dwnld_pack
//  Description : Packs the ioctl byte stream into masked 16-bit SDRAM writes.
//                Strips HEADER bytes, selects one of four banks, merges byte
//                pairs, buffers words in a FIFO and issues them with a
//                prog_we/prog_rdy handshake. dwnld_busy covers the download
//                and the write-back tail.
//  Ports       : clk, rst - clock, synchronous active-high reset
//                bus      - jtframe_dwnld_if.slave (ioctl_*, prog_*,
//                           downloading, dwnld_busy, ovf)
//  Macro       : JTFRAME_DWNLD_BSWAP_EN - byte-swap words at the FIFO output
//  Revision    : 1.0 - initial release
// ============================================================================
module jtframe_dwnld_pack
    import jtframe_dwnld_pkg::*;
#(
    parameter int          SDRAMW     = 23,
    parameter int          HEADER     = 0,
    parameter logic [24:0] BA1_START  = 25'h1F_FFFF,
    parameter logic [24:0] BA2_START  = 25'h1F_FFFF,
    parameter logic [24:0] BA3_START  = 25'h1F_FFFF,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    jtframe_dwnld_if.slave bus
);
    localparam logic [24:0] HDR = 25'(HEADER);

    // ---------------- byte mapping ----------------
    logic            hdr_ok, take, lane;
    logic [24:0]     a, bank_start, rel;
    logic [1:0]      ba;
    logic [OFFW-1:0] off;

    generate
        if (HEADER == 0) begin : g_no_header
            assign hdr_ok = 1'b1;
        end else begin : g_header
            assign hdr_ok = (bus.ioctl_addr >= HDR);
        end
    endgenerate

    assign take = bus.ioctl_wr & hdr_ok;
    assign a    = bus.ioctl_addr - HDR;

    always_comb begin
        ba         = 2'd0;
        bank_start = '0;
        if (a >= BA3_START) begin
            ba = 2'd3; bank_start = BA3_START;
        end else if (a >= BA2_START) begin
            ba = 2'd2; bank_start = BA2_START;
        end else if (a >= BA1_START) begin
            ba = 2'd1; bank_start = BA1_START;
        end
    end

    // Lane parity is taken relative to the bank start
    assign rel  = a - bank_start;
    assign lane = rel[0];
    assign off  = rel[24:1];

    // ---------------- packer ----------------
    pack_state_t     pk_state_q, pk_state_d;
    logic [1:0]      pend_ba_q, pend_ba_d;
    logic [OFFW-1:0] pend_off_q, pend_off_d;
    logic [7:0]      pend_data_q, pend_data_d;
    logic [1:0]      pk_n;          // words produced this cycle, in order
    entry_t          pk_e0, pk_e1;
    entry_t          byte_ent, pend_ent, full_ent;

    assign byte_ent = '{ba: ba, addr: off,
                        data: lane ? {bus.ioctl_dout, 8'h00} : {8'h00, bus.ioctl_dout},
                        mask: lane ? MASK_HI : MASK_LO};
    assign pend_ent = '{ba: pend_ba_q, addr: pend_off_q,
                        data: {8'h00, pend_data_q}, mask: MASK_LO};
    assign full_ent = '{ba: pend_ba_q, addr: pend_off_q,
                        data: {bus.ioctl_dout, pend_data_q}, mask: MASK_FULL};

    always_comb begin
        pk_state_d  = pk_state_q;
        pend_ba_d   = pend_ba_q;
        pend_off_d  = pend_off_q;
        pend_data_d = pend_data_q;
        pk_n        = 2'd0;
        pk_e0       = '0;
        pk_e1       = '0;
        if (take) begin
            if (pk_state_q == PK_HALF && lane && ba == pend_ba_q && off == pend_off_q) begin
                pk_e0      = full_ent;
                pk_n       = 2'd1;
                pk_state_d = PK_EMPTY;
            end else begin
                if (pk_state_q == PK_HALF) begin
                    pk_e0 = pend_ent;
                    pk_n  = 2'd1;
                end
                if (lane) begin
                    if (pk_n == 2'd0) pk_e0 = byte_ent;
                    else              pk_e1 = byte_ent;
                    pk_n       = pk_n + 2'd1;
                    pk_state_d = PK_EMPTY;
                end else begin
                    pend_ba_d   = ba;
                    pend_off_d  = off;
                    pend_data_d = bus.ioctl_dout;
                    pk_state_d  = PK_HALF;
                end
            end
        end
        // The byte of this cycle is taken first, then a lone low byte flushes
        if (!bus.downloading && pk_state_d == PK_HALF) begin
            if (pk_n == 2'd0) pk_e0 = '{ba: pend_ba_d, addr: pend_off_d,
                                         data: {8'h00, pend_data_d}, mask: MASK_LO};
            else              pk_e1 = '{ba: pend_ba_d, addr: pend_off_d,
                                         data: {8'h00, pend_data_d}, mask: MASK_LO};
            pk_n       = pk_n + 2'd1;
            pk_state_d = PK_EMPTY;
        end
    end

    // ---------------- skid: one FIFO push per cycle, oldest first ----------------
    logic   skid_v_q, skid_v_d, skid_drop, push;
    entry_t skid_q, skid_d, push_ent;

    always_comb begin
        skid_v_d  = 1'b0;
        skid_d    = skid_q;
        push      = 1'b0;
        push_ent  = '0;
        skid_drop = 1'b0;
        if (skid_v_q) begin
            push     = 1'b1;
            push_ent = skid_q;
            if (pk_n != 2'd0) begin
                skid_v_d = 1'b1;
                skid_d   = pk_e0;
            end
            // Only reachable when the source outruns the sustained rate
            skid_drop = (pk_n == 2'd2);
        end else if (pk_n != 2'd0) begin
            push     = 1'b1;
            push_ent = pk_e0;
            if (pk_n == 2'd2) begin
                skid_v_d = 1'b1;
                skid_d   = pk_e1;
            end
        end
    end

    // ---------------- FIFO ----------------
    logic   fifo_full, fifo_empty, pop;
    entry_t fifo_dout, out_ent;

    jtframe_dwnld_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (push_ent),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef JTFRAME_DWNLD_BSWAP_EN
    assign out_ent = lane_swap(fifo_dout);
`else
    assign out_ent = fifo_dout;
`endif

    // ---------------- writer ----------------
    wr_state_t         wr_state_q, wr_state_d;
    logic              prog_we_q, prog_we_d;
    logic [SDRAMW-1:0] prog_addr_q, prog_addr_d;
    logic [15:0]       prog_data_q, prog_data_d;
    logic [1:0]        prog_mask_q, prog_mask_d;
    logic [1:0]        prog_ba_q, prog_ba_d;

    always_comb begin
        wr_state_d  = wr_state_q;
        pop         = 1'b0;
        prog_we_d   = prog_we_q;
        prog_addr_d = prog_addr_q;
        prog_data_d = prog_data_q;
        prog_mask_d = prog_mask_q;
        prog_ba_d   = prog_ba_q;
        case (wr_state_q)
            WR_IDLE: if (!fifo_empty) begin
                pop         = 1'b1;
                prog_we_d   = 1'b1;
                prog_addr_d = SDRAMW'(out_ent.addr);
                prog_data_d = out_ent.data;
                prog_mask_d = out_ent.mask;
                prog_ba_d   = out_ent.ba;
                wr_state_d  = WR_WRITE;
            end
            WR_WRITE: if (bus.prog_rdy) begin
                prog_we_d  = 1'b0;
                wr_state_d = WR_IDLE;
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    // ---------------- status ----------------
    logic busy_q, busy_d, ovf_q, ovf_d, quiet;

    assign quiet  = ~bus.downloading & (pk_state_q == PK_EMPTY) & ~skid_v_q
                  & fifo_empty & (wr_state_q == WR_IDLE);
    assign busy_d = bus.downloading ? 1'b1 : (quiet ? 1'b0 : busy_q);
    assign ovf_d  = ovf_q | skid_drop | (push & fifo_full & ~pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            pk_state_q  <= PK_EMPTY;
            pend_ba_q   <= '0;
            pend_off_q  <= '0;
            pend_data_q <= '0;
            skid_v_q    <= 1'b0;
            skid_q      <= '0;
            wr_state_q  <= WR_IDLE;
            prog_we_q   <= 1'b0;
            prog_addr_q <= '0;
            prog_data_q <= '0;
            prog_mask_q <= MASK_NONE;
            prog_ba_q   <= '0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            pk_state_q  <= pk_state_d;
            pend_ba_q   <= pend_ba_d;
            pend_off_q  <= pend_off_d;
            pend_data_q <= pend_data_d;
            skid_v_q    <= skid_v_d;
            skid_q      <= skid_d;
            wr_state_q  <= wr_state_d;
            prog_we_q   <= prog_we_d;
            prog_addr_q <= prog_addr_d;
            prog_data_q <= prog_data_d;
            prog_mask_q <= prog_mask_d;
            prog_ba_q   <= prog_ba_d;
            busy_q      <= busy_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.prog_we    = prog_we_q;
    assign bus.prog_addr  = prog_addr_q;
    assign bus.prog_data  = prog_data_q;
    assign bus.prog_mask  = prog_mask_q;
    assign bus.prog_ba    = prog_ba_q;
    assign bus.dwnld_busy = busy_q;
    assign bus.ovf        = ovf_q;
endmodule
`default_nettype wire
